// File: rtl/bsg_dram_bw_req_scheduler.sv
// Trace-to-DRAM request scheduler with credit-limited issue, completion/busy statistics and end-of-test detection.
// Optional read-latency tracking is enabled by defining BSG_DRAM_BW_SCHED_LATENCY_EN.
module bsg_dram_bw_req_scheduler #(
  parameter int payload_width_p   = 10,
  parameter int addr_width_p      = 28,
  parameter int lg_block_bytes_p  = 6,
  parameter int max_outstanding_p = 8,
  parameter int counter_width_p   = 32
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   tr_v_i,
  input  logic [payload_width_p-1:0]             tr_data_i,
  output logic                                   tr_yumi_o,
  input  logic                                   tr_done_i,
  output logic                                   dram_v_o,
  output logic                                   dram_write_not_read_o,
  output logic [addr_width_p-1:0]                dram_addr_o,
  input  logic                                   dram_yumi_i,
  input  logic                                   dram_rd_done_i,
  input  logic                                   dram_wr_done_i,
  output logic                                   done_o,
  output logic                                   error_o,
  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
  output logic [counter_width_p-1:0]             busy_cycles_o,
  output logic [counter_width_p-1:0]             reads_done_o,
  output logic [counter_width_p-1:0]             writes_done_o
`ifdef BSG_DRAM_BW_SCHED_LATENCY_EN
  ,
  output logic [counter_width_p-1:0]             max_rd_latency_o
`endif
);

  localparam int unsigned ow_w  = $clog2(max_outstanding_p+1);
  localparam int unsigned ow1_w = ow_w + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e            state, state_n;
  logic [ow_w-1:0]   outstanding, outstanding_n;
  logic [ow1_w-1:0]  up, down;
  logic              accept, underflow, issue_en, busy_inc, fifo_err;

  assign dram_write_not_read_o = tr_data_i[payload_width_p-1];
  assign dram_addr_o = addr_width_p'(tr_data_i[payload_width_p-2:0]) << lg_block_bytes_p;
  assign accept        = tr_yumi_o;
  assign outstanding_o = outstanding;

  // Issue is gated on the registered count, so accept and a completion never meet at full.
  always_comb begin
    issue_en  = (state == IDLE) || (state == RUN);
    dram_v_o  = tr_v_i & issue_en & (outstanding < ow_w'(max_outstanding_p));
    tr_yumi_o = dram_v_o & dram_yumi_i;
    done_o    = (state == DONE);
  end

  always_comb begin
    up            = {1'b0, outstanding} + ow1_w'(accept);
    down          = ow1_w'(dram_rd_done_i) + ow1_w'(dram_wr_done_i);
    underflow     = (up < down);
    outstanding_n = underflow ? '0 : ow_w'(up - down);
    busy_inc      = (state == RUN) || (state == DRAIN) || ((state == IDLE) && accept);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = RUN;
               else if (tr_done_i && !tr_v_i) state_n = DONE;
      RUN:     if (tr_done_i && !tr_v_i && !accept) state_n = DRAIN;
      DRAIN:   if (outstanding_n == '0) state_n = DONE;
      default: state_n = DONE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= IDLE;
      outstanding   <= '0;
      busy_cycles_o <= '0;
      reads_done_o  <= '0;
      writes_done_o <= '0;
      error_o       <= 1'b0;
    end else begin
      state       <= state_n;
      outstanding <= outstanding_n;
      if (busy_inc && !(&busy_cycles_o)) busy_cycles_o <= busy_cycles_o + 1'b1;
      if (dram_rd_done_i && !(&reads_done_o)) reads_done_o <= reads_done_o + 1'b1;
      if (dram_wr_done_i && !(&writes_done_o)) writes_done_o <= writes_done_o + 1'b1;
      if ((dram_yumi_i && !dram_v_o) || underflow || fifo_err) error_o <= 1'b1;
    end
  end

`ifdef BSG_DRAM_BW_SCHED_LATENCY_EN
  localparam int unsigned pt_w = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  logic [counter_width_p-1:0] cycle_cnt, latency;
  logic [counter_width_p-1:0] ts_mem [max_outstanding_p];
  logic [pt_w-1:0]            wptr, rptr;
  logic [ow_w-1:0]            fcnt;
  logic                       rd_acc, full, empty, push, pop;

  // Reads return in order, so the oldest timestamp belongs to the current completion.
  always_comb begin
    rd_acc   = accept & ~dram_write_not_read_o;
    full     = (fcnt == ow_w'(max_outstanding_p));
    empty    = (fcnt == '0);
    pop      = dram_rd_done_i & ~empty;
    push     = rd_acc & (~full | pop);
    fifo_err = (dram_rd_done_i & empty) | (rd_acc & full & ~pop);
    latency  = cycle_cnt - ts_mem[rptr];
  end

  always_ff @(posedge clk_i) begin
    if (push) ts_mem[wptr] <= cycle_cnt;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cycle_cnt        <= '0;
      wptr             <= '0;
      rptr             <= '0;
      fcnt             <= '0;
      max_rd_latency_o <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      fcnt      <= fcnt + ow_w'(push) - ow_w'(pop);
      if (push) wptr <= (wptr == pt_w'(max_outstanding_p-1)) ? '0 : wptr + 1'b1;
      if (pop) begin
        rptr <= (rptr == pt_w'(max_outstanding_p-1)) ? '0 : rptr + 1'b1;
        if (latency > max_rd_latency_o) max_rd_latency_o <= latency;
      end
    end
  end
`else
  assign fifo_err = 1'b0;
`endif

endmodule

// File: doc/bsg_dram_bw_req_scheduler.md
Name: bsg_dram_bw_req_scheduler

Overview:
- Sits between a trace-replay packet source and a DRAM memory channel (DRAMSim3-backed or real controller) in bandwidth benches.
- Converts trace packets into DRAM read/write requests and caps in-flight requests with a credit counter.
- Tracks completions, detects end of test (trace exhausted and all responses returned), and reports busy-cycle and completion counts for bandwidth computation.

Parameters:
- payload_width_p, 10, trace payload width; bit [payload_width_p-1] = write_not_read, bits [payload_width_p-2:0] = block index.
- addr_width_p, 28, DRAM byte-address width.
- lg_block_bytes_p, 6, log2 of the block size; address = block index << lg_block_bytes_p, zero-extended to addr_width_p.
- max_outstanding_p, 8, maximum in-flight requests (reads plus writes); must be at least 1.
- counter_width_p, 32, width of the statistics counters.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- tr_v_i  in  1  trace packet valid.
- tr_data_i  in  payload_width_p  trace packet.
- tr_yumi_o  out  1  trace packet consumed.
- tr_done_i  in  1  trace source finished; level signal, stays high once set.
- dram_v_o  out  1  request valid.
- dram_write_not_read_o  out  1  request type.
- dram_addr_o  out  addr_width_p  request byte address.
- dram_yumi_i  in  1  channel accepts the request this cycle.
- dram_rd_done_i  in  1  one read completion (data returned).
- dram_wr_done_i  in  1  one write completion.
- done_o  out  1  test complete.
- error_o  out  1  sticky protocol error.
- outstanding_o  out  clog2(max_outstanding_p+1)  current in-flight count.
- busy_cycles_o  out  counter_width_p  cycles from the first accepted request to completion.
- reads_done_o  out  counter_width_p  read completions counted.
- writes_done_o  out  counter_width_p  write completions counted.

Behaviour:
- Reset values: all counters 0, state IDLE, done_o=0, error_o=0, dram_v_o=0, tr_yumi_o=0.
- Reset asserted mid-test clears everything in the same edge. Completions arriving in the first cycle after reset are counted normally.
- FSM states:
  - IDLE: waits for tr_v_i. Goes to RUN on the first accept. Goes directly to DONE if tr_done_i=1 and tr_v_i=0.
  - RUN: issues requests. Goes to DRAIN when tr_done_i=1, tr_v_i=0, and no accept occurs this cycle.
  - DRAIN: no issue. Goes to DONE when outstanding is 0, including a completion in this cycle that brings it to 0.
  - DONE: absorbing until reset.
- Issue path is combinational, zero-latency pass-through:
  - dram_v_o = tr_v_i & (state is IDLE or RUN) & (outstanding < max_outstanding_p).
  - dram_write_not_read_o and dram_addr_o are decoded from tr_data_i.
  - tr_yumi_o = dram_v_o & dram_yumi_i.
- dram_yumi_i while dram_v_o=0 sets error_o and is otherwise ignored.
- Outstanding update: next = cur + accept − rd_done − wr_done. Accept and one completion in the same cycle leaves the count unchanged. Two completions in one cycle give −2.
- Credit full (outstanding = max): dram_v_o=0. An accept and a completion cannot coincide at full, because issue is gated on the registered count.
- Underflow: a completion that would take the count below 0 sets error_o; the count saturates at 0 and the completion counters still increment.
- busy_cycles_o increments every cycle in RUN and DRAIN. It does not count in IDLE or DONE. The IDLE→RUN cycle is counted as 1.
- All statistics counters saturate at all-ones; they do not wrap.
- done_o = (state == DONE), registered.

Optional Feature:
- Macro: BSG_DRAM_BW_SCHED_LATENCY_EN.
- With the macro defined:
  - Adds output max_rd_latency_o [counter_width_p] (reset 0).
  - Adds an issue-timestamp FIFO of depth max_outstanding_p that pushes a free-running cycle count on each read accept and pops on each dram_rd_done_i. In-order read return is required.
  - Latency = completion cycle − issue cycle; max_rd_latency_o tracks the maximum.
  - A pop from an empty FIFO sets error_o.
- Without the macro: no FIFO, no port, and behaviour is otherwise identical.

Test Plan:
- Single read: packet 10'h005, dram_yumi_i=1 at cycle 0, rd_done at cycle 20, tr_done_i set after → dram_addr_o=0x140 and write_not_read=0; done_o rises the cycle after rd_done, busy_cycles_o=21, reads_done_o=1.
- Credit limit: 12 reads with max_outstanding_p=8, channel always yumi, no completions → exactly 8 accepted and dram_v_o=0 with tr_v_i=1; one rd_done → 9th accepted the next cycle.
- Simultaneous events: accept, rd_done and wr_done in the same cycle starting at outstanding 3 → outstanding 2; reads_done_o and writes_done_o each +1.
- Underflow: wr_done with outstanding 0 → error_o=1 and stays 1, outstanding_o=0, writes_done_o=1.
- Empty trace and reset: tr_done_i=1 with no packets → done_o=1 within 2 cycles and busy_cycles_o=0. Reset asserted in DRAIN with 4 outstanding → all outputs return to reset values the next cycle.
- Latency (macro on): reads accepted at cycles 0 and 1, returned at 30 and 50 → max_rd_latency_o=49.
